// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, one bit per clock, LSB first.
// Results are registered and only update on the completion edge.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic             sub_in,
  input  logic             cin_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             ovf_out,
  output logic             busy_out,
  output logic             done_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;
  logic             last_bit;

  assign fa_s     = a_sh[0] ^ b_sh[0] ^ carry;
  assign fa_c     = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  assign last_bit = (cnt == LAST);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_in) state_next = BUSY;
      BUSY:    if (last_bit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1, so the B operand is inverted once at capture.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum_out  <= '0;
      cout_out <= 1'b0;
      ovf_out  <= 1'b0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            a_sh     <= a_in;
            b_sh     <= sub_in ? ~b_in : b_in;
            carry    <= sub_in ? 1'b1 : cin_in;
            res_sh   <= '0;
            cnt      <= '0;
            busy_out <= 1'b1;
          end
        end
        BUSY: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {fa_s, res_sh[WIDTH-1:1]};
          carry  <= fa_c;
          cnt    <= cnt + 1'b1;
          // carry still holds the carry into the MSB on the last step
          if (last_bit) begin
            sum_out  <= {fa_s, res_sh[WIDTH-1:1]};
            cout_out <= fa_c;
            ovf_out  <= carry ^ fa_c;
            busy_out <= 1'b0;
            done_out <= 1'b1;
            cnt      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed cases plus random
// operations, with a scoreboard queue checked by a monitor on each done pulse.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;
  logic         done;

  typedef struct {
    logic [W+1:0] res;
    int           due;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .start_in (start),
    .sub_in   (sub),
    .cin_in   (cin),
    .a_in     (a),
    .b_in     (b),
    .sum_out  (sum),
    .cout_out (cout),
    .ovf_out  (ovf),
    .busy_out (busy),
    .done_out (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Reference result as {sum, cout, ovf} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s, input logic c);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         v;
    if (s) begin
      full = {1'b0, x} + {1'b0, ~y} + 1;
      r = full[W-1:0];
      v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      r = full[W-1:0];
      v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end
    return {r, full[W], v};
  endfunction

  // Caller is positioned at a negedge with the DUT idle; start is accepted on the next posedge.
  task automatic apply_stimulus(input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic s, input logic c);
    exp_t e;
    a = x; b = y; sub = s; cin = c; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.res = model(x, y, s, c);
    e.due = cycle + W;
    exp_q.push_back(e);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    if (!done) check_output("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic monitor();
    int   busy_run;
    logic prev_done;
    exp_t e;
    busy_run = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_run = 0;
      end else if (done) begin
        check_output("done_width", 32'(prev_done), 32'd0);
        check_output("busy_len", busy_run, W);
        busy_run = 0;
        if (exp_q.size() == 0) begin
          check_output("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_output("result", {sum, cout, ovf}, 32'(e.res));
          check_output("latency", cycle, e.due);
        end
      end else if (busy) begin
        busy_run++;
      end
      prev_done = done;
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    #3;
    check_output("reset_outputs", {sum, cout, ovf, busy, done}, 32'd0);
    #9 rst_n = 1'b1;
    @(negedge clk);

    apply_stimulus(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done();
    @(negedge clk);
    apply_stimulus(8'h05, 8'h07, 1'b1, 1'b0);
    wait_done();
    @(negedge clk);
    apply_stimulus(8'h05, 8'h07, 1'b1, 1'b1);
    wait_done();
    @(negedge clk);
    apply_stimulus(8'h7F, 8'h01, 1'b0, 1'b1);
    wait_done();
    @(negedge clk);
    apply_stimulus(8'h80, 8'h01, 1'b1, 1'b0);
    wait_done();
    @(negedge clk);

    // Disturb inputs and re-pulse start mid-operation; result must follow captured operands.
    apply_stimulus(8'h3C, 8'h5A, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    a = 8'hAA; b = 8'h55; sub = 1'b1; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    // Back-to-back: start in the done cycle itself.
    apply_stimulus(8'hC3, 8'h2E, 1'b1, 1'b0);
    wait_done();
    @(negedge clk);

    // Abort mid-operation with reset; no done may follow.
    apply_stimulus(8'h99, 8'h66, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("abort_outputs", {sum, cout, ovf, busy, done}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus(8'h12, 8'h34, 1'b0, 1'b0);
    wait_done();
    @(negedge clk);

    // Random operations, sometimes back-to-back, with input noise while busy.
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      while (!done && busy) begin
        @(negedge clk);
        if (!done) begin
          a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        end
      end
      wait_done();
      if ($urandom_range(1, 0) == 0) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check_output("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits; legal range 2..64.
REQ-002 SHALL have port clk_in  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n_in  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start_in  input  1  request a new operation; sampled on rising edge.
REQ-005 SHALL have port sub_in  input  1  mode: 0 = add, 1 = subtract (a_in - b_in); sampled with start_in.
REQ-006 SHALL have port cin_in  input  1  carry-in for add mode; ignored in subtract mode.
REQ-007 SHALL have port a_in  input  WIDTH  operand A.
REQ-008 SHALL have port b_in  input  WIDTH  operand B.
REQ-009 SHALL have port sum_out  output  WIDTH  registered result.
REQ-010 SHALL have port cout_out  output  1  registered carry-out; in subtract mode 1 means no borrow.
REQ-011 SHALL have port ovf_out  output  1  registered two's-complement signed overflow flag.
REQ-012 SHALL have port busy_out  output  1  high while an operation is in progress.
REQ-013 SHALL have port done_out  output  1  one-cycle completion pulse.

Function
REQ-014 SHALL use a single 1-bit full-adder cell, processing one bit per clock, LSB first; a parallel WIDTH-bit adder is not permitted.
REQ-015 SHALL implement FSM states IDLE and BUSY; IDLE -> BUSY on a rising edge with start_in=1; BUSY -> IDLE on the edge that processes bit WIDTH-1.
REQ-016 On acceptance (edge E0), SHALL capture a_in, b_in, sub_in and cin_in into internal registers; input changes after E0 SHALL NOT affect the result.
REQ-017 In subtract mode, SHALL use ~b_in as the B operand and force carry-in to 1; in add mode, SHALL use b_in and cin_in.
REQ-018 SHALL process bit i at edge E(i+1), for i = 0..WIDTH-1; the bit counter SHALL be $clog2(WIDTH) bits wide and SHALL clear on acceptance.
REQ-019 At edge E(WIDTH), SHALL update sum_out, cout_out and ovf_out together and assert done_out for exactly one cycle; latency from start to done is WIDTH cycles.
REQ-020 SHALL compute ovf_out as (carry into MSB) XOR (carry out of MSB).
REQ-021 sum_out, cout_out and ovf_out SHALL hold their values until the next completion; partial results SHALL never be visible on them.
REQ-022 busy_out SHALL be 1 from after E0 through E(WIDTH), and 0 otherwise.
REQ-023 SHALL ignore start_in while BUSY, with no restart and no effect on the result.
REQ-024 SHALL accept start_in=1 in the cycle done_out=1, since the FSM is IDLE; the next done SHALL follow WIDTH cycles later, allowing back-to-back operation.
REQ-025 SHALL leave done_out low on any cycle that does not complete an operation; done_out SHALL never stay high for two consecutive cycles.

Reset
REQ-026 While rst_n_in=0, SHALL immediately force FSM=IDLE, counter=0, carry=0, and sum_out, cout_out, ovf_out, busy_out, done_out all to 0, with no dependence on clk_in.
REQ-027 On reset mid-operation, SHALL abort the operation silently with no done_out pulse; the first start after release SHALL produce a correct result.
REQ-028 SHALL accept start_in on the first rising edge after rst_n_in deasserts.

Verification (WIDTH=8)
REQ-029 Reset: assert rst_n_in=0 between clock edges -> all outputs 0 at once; busy_out=0, done_out=0.
REQ-030 Add with wrap: a=FF, b=01, cin=0, sub=0 -> exactly 8 cycles later sum=00, cout=1, ovf=0, done pulse width 1; busy high for 8 cycles.
REQ-031 Subtract with borrow: a=05, b=07, sub=1 -> sum=FE, cout=0, ovf=0; a second run with cin_in=1 gives the same result, since cin_in is ignored.
REQ-032 Signed overflow: a=7F, b=01, cin=1, add -> sum=81, cout=0, ovf=1; then a=80, b=01, sub=1 -> sum=7F, cout=1, ovf=1.
REQ-033 Robustness: change a_in/b_in and pulse start_in at bit 3 of an op -> result matches the captured operands, with no restart; start_in in the done cycle -> second done exactly 8 cycles later with the correct result.
REQ-034 Abort: pull rst_n_in low at bit 4 -> outputs 0, no done pulse; after release, a=12, b=34 add -> sum=46, cout=0, ovf=0.
